mem_array_sdp: RTL and testbench
================================

MEM_ARRAY_SDP -- requirements
Module: mem_array_sdp

Interface
REQ-001 SHALL have parameter MEM_TYPE, default "REG", meaning storage implementation style; legal values "REG", "LUT", "BRAM".
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning word width in bits; must be a multiple of LANE_WIDTH.
REQ-003 SHALL have parameter LANE_WIDTH, default 8, meaning bits per write-enable lane; NUM_LANES = DATA_WIDTH/LANE_WIDTH.
REQ-004 SHALL have parameter ADDR_WIDTH, default 4, meaning address bits; DEPTH = 2**ADDR_WIDTH.
REQ-005 SHALL have parameter READ_LATENCY, default 1, meaning cycles from rd_en to rd_valid; legal values 1, 2.
REQ-006 SHALL have parameter RDW_MODE, default "OLD", meaning same-address read-during-write result; legal values "OLD", "NEW".
REQ-007 SHALL have parameter INIT_VALUE, default 0, DATA_WIDTH bits, meaning the word written by the clear sweep.
REQ-008 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-009 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-010 SHALL have port wr_en, input, 1 bit, write request.
REQ-011 SHALL have port wr_addr, input, ADDR_WIDTH bits, write address.
REQ-012 SHALL have port wr_data, input, DATA_WIDTH bits, write data.
REQ-013 SHALL have port wr_be, input, NUM_LANES bits, per-lane write enable; bit i covers wr_data[i*LANE_WIDTH +: LANE_WIDTH].
REQ-014 SHALL have port rd_en, input, 1 bit, read request.
REQ-015 SHALL have port rd_addr, input, ADDR_WIDTH bits, read address.
REQ-016 SHALL have port rd_data, output, DATA_WIDTH bits, registered read data.
REQ-017 SHALL have port rd_valid, output, 1 bit, one-cycle pulse qualifying rd_data.
REQ-018 SHALL have port init_req, input, 1 bit, request a clear sweep.
REQ-019 SHALL have port busy, output, 1 bit, high while a clear sweep is running.

Function
REQ-020 SHALL abort elaboration with a fatal error on any illegal MEM_TYPE, READ_LATENCY or RDW_MODE value, or when DATA_WIDTH is not a multiple of LANE_WIDTH.
REQ-021 SHALL use a clear FSM with states IDLE and CLEAR: IDLE->CLEAR on init_req; CLEAR->IDLE after the cycle that writes address DEPTH-1.
REQ-022 SHALL, in CLEAR, write INIT_VALUE (all lanes) to one address per cycle, ascending from 0, so that busy is high for exactly DEPTH cycles.
REQ-023 SHALL ignore wr_en, rd_en and init_req while busy=1; no array update, no new rd_valid.
REQ-024 SHALL give init_req priority over wr_en and rd_en in the IDLE cycle where it is sampled; that cycle's write and read are dropped.
REQ-025 SHALL, in IDLE, on wr_en=1, update only the lanes whose wr_be bit is 1; wr_be=0 leaves the word unchanged.
REQ-026 SHALL, in IDLE, on rd_en=1 sampled at edge N, drive rd_valid=1 and the addressed word on rd_data after edge N+READ_LATENCY-1 (i.e. READ_LATENCY cycles later), pulsing rd_valid for one cycle per accepted read.
REQ-027 SHALL accept a read every cycle (full throughput) at both latencies, with reads returned in order.
REQ-028 SHALL hold rd_data at its last value when rd_valid=0.
REQ-029 SHALL, for a same-cycle read and write to the same address, return the pre-write word when RDW_MODE="OLD", and the word after byte-lane merging when RDW_MODE="NEW".
REQ-030 SHALL complete reads already in the READ_LATENCY=2 pipeline when a sweep starts; data is taken from the array before the sweep.
REQ-031 SHALL implement MEM_TYPE as a synthesis style hint only; all three values are cycle-identical at the ports.

Reset
REQ-032 SHALL, on rst_n=0, asynchronously clear rd_data to 0, rd_valid to 0 and the read pipeline, and force FSM state IDLE with sweep address 0.
REQ-033 SHALL NOT reset array contents via rst_n.
REQ-034 SHALL enter CLEAR on the first rising edge after rst_n deasserts, as if init_req were asserted, so busy=1 for DEPTH cycles after every reset.
REQ-035 SHALL, when reset is asserted mid-sweep, abort the sweep and restart from address 0 after release.

Verification
REQ-036 SHALL cover: release reset with ADDR_WIDTH=4 -> busy high exactly 16 cycles; then read all 16 addresses -> each returns INIT_VALUE.
REQ-037 SHALL cover: write 0xAABBCCDD to address 3 with wr_be=4'b1111, then write 0x11223344 with wr_be=4'b0101 -> reading address 3 returns 0xAA22CC44.
REQ-038 SHALL cover: with READ_LATENCY=2, issue rd_en on 4 consecutive cycles, addresses 0..3 -> rd_valid high for 4 consecutive cycles starting 2 cycles after the first request, with data in order.
REQ-039 SHALL cover: address 5 holds 0x0; same-cycle write 0x12345678 (wr_be all 1) and read of address 5 -> rd_data=0x0 for "OLD", 0x12345678 for "NEW".
REQ-040 SHALL cover: assert init_req together with wr_en to address 2 -> write dropped, busy high 16 cycles, address 2 reads INIT_VALUE; rd_en during busy yields no rd_valid.
REQ-041 SHALL cover: assert rst_n=0 at sweep address 7 -> rd_valid=0 and rd_data=0 immediately; after release busy high a full 16 cycles from address 0.

Source files
------------

// File: rtl/mem_array_sdp.sv
// Simple dual-port memory: one write port with per-lane enables, one read port with 1 or 2
// cycle latency, and a clear sweep that rewrites every word with INIT_VALUE.
module mem_array_sdp #(
  parameter string                   MEM_TYPE     = "REG",
  parameter int                      DATA_WIDTH   = 32,
  parameter int                      LANE_WIDTH   = 8,
  parameter int                      ADDR_WIDTH   = 4,
  parameter int                      READ_LATENCY = 1,
  parameter string                   RDW_MODE     = "OLD",
  parameter logic [DATA_WIDTH-1:0]   INIT_VALUE   = '0,
  localparam int                     NUM_LANES    = DATA_WIDTH / LANE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_LANES-1:0]  wr_be,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  init_req,
  output logic                  busy,
  output logic                  dbg_state,
  output logic [ADDR_WIDTH-1:0] dbg_sweep_addr
);

  localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam bit                    RDW_NEW   = (RDW_MODE == "NEW");

  if (!(MEM_TYPE == "REG" || MEM_TYPE == "LUT" || MEM_TYPE == "BRAM")) begin : g_bad_mem_type
    $fatal(1, "mem_array_sdp: illegal MEM_TYPE %s", MEM_TYPE);
  end
  if (!(READ_LATENCY == 1 || READ_LATENCY == 2)) begin : g_bad_latency
    $fatal(1, "mem_array_sdp: illegal READ_LATENCY %0d", READ_LATENCY);
  end
  if (!(RDW_MODE == "OLD" || RDW_MODE == "NEW")) begin : g_bad_rdw
    $fatal(1, "mem_array_sdp: illegal RDW_MODE %s", RDW_MODE);
  end
  if ((DATA_WIDTH % LANE_WIDTH) != 0) begin : g_bad_lanes
    $fatal(1, "mem_array_sdp: DATA_WIDTH %0d not a multiple of LANE_WIDTH %0d",
           DATA_WIDTH, LANE_WIDTH);
  end

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_e;

  state_e                  state, state_nxt;
  logic                    init_pend;
  logic                    start_clear;
  logic [ADDR_WIDTH-1:0]   sweep_addr;
  logic                    wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0]   rd_word;
  // MEM_TYPE only steers how a synthesis flow maps this array; behaviour is identical.
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Handshake: rd_en has no backpressure; it is accepted whenever the block is idle and no
  // sweep is being started, and each accepted read yields exactly one in-order rd_valid pulse.
  always_comb begin
    state_nxt   = state;
    start_clear = 1'b0;
    case (state)
      IDLE: begin
        if (init_req || init_pend) begin
          state_nxt   = CLEAR;
          start_clear = 1'b1;
        end
      end
      CLEAR: begin
        if (sweep_addr == LAST_ADDR) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_acc         = (state == IDLE) && !start_clear && wr_en;
  assign rd_acc         = (state == IDLE) && !start_clear && rd_en;
  assign busy           = (state == CLEAR);
  assign dbg_state      = state;
  assign dbg_sweep_addr = sweep_addr;

  // init_pend makes the first edge after reset behave like an init_req.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      init_pend  <= 1'b1;
      sweep_addr <= '0;
    end else begin
      state <= state_nxt;
      if (start_clear) begin
        init_pend  <= 1'b0;
        sweep_addr <= '0;
      end else if (state == CLEAR) begin
        sweep_addr <= sweep_addr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[sweep_addr] <= INIT_VALUE;
    end else if (wr_acc) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (wr_be[i]) mem[wr_addr][i*LANE_WIDTH +: LANE_WIDTH] <= wr_data[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  // NEW mode forwards the enabled lanes of a same-cycle write into the read word.
  always_comb begin
    rd_word = mem[rd_addr];
    if (RDW_NEW && wr_acc && (wr_addr == rd_addr)) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (wr_be[i]) rd_word[i*LANE_WIDTH +: LANE_WIDTH] = wr_data[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  if (READ_LATENCY == 1) begin : g_lat1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_valid <= 1'b0;
        rd_data  <= '0;
      end else begin
        rd_valid <= rd_acc;
        if (rd_acc) rd_data <= rd_word;
      end
    end
  end else begin : g_lat2
    logic                  p1_valid;
    logic [DATA_WIDTH-1:0] p1_data;

    // Data is captured at acceptance, so a sweep starting behind it cannot alter it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        p1_valid <= 1'b0;
        p1_data  <= '0;
        rd_valid <= 1'b0;
        rd_data  <= '0;
      end else begin
        p1_valid <= rd_acc;
        if (rd_acc) p1_data <= rd_word;
        rd_valid <= p1_valid;
        if (p1_valid) rd_data <= p1_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_array_sdp.sv
// Bench for mem_array_sdp: instance a (latency 1, OLD, init 0) and instance b (latency 2, NEW,
// non-zero init) share all inputs and are checked against a reference model and read queues.
module tb_mem_array_sdp;

  localparam int              DW     = 32;
  localparam int              AW     = 4;
  localparam int              NL     = 4;
  localparam int              DEPTH  = 16;
  localparam logic [DW-1:0]   INIT_B = 32'hC3C3_5A5A;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [NL-1:0] wr_be = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          init_req = 1'b0;

  logic [DW-1:0] rd_data_a, rd_data_b;
  logic          rd_valid_a, rd_valid_b, busy_a, busy_b, dbg_state_a, dbg_state_b;
  logic [AW-1:0] dbg_sweep_a, dbg_sweep_b;

  mem_array_sdp #(
    .MEM_TYPE("REG"), .DATA_WIDTH(DW), .LANE_WIDTH(8), .ADDR_WIDTH(AW),
    .READ_LATENCY(1), .RDW_MODE("OLD"), .INIT_VALUE('0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_valid(rd_valid_a), .init_req(init_req), .busy(busy_a),
    .dbg_state(dbg_state_a), .dbg_sweep_addr(dbg_sweep_a)
  );

  mem_array_sdp #(
    .MEM_TYPE("BRAM"), .DATA_WIDTH(DW), .LANE_WIDTH(8), .ADDR_WIDTH(AW),
    .READ_LATENCY(2), .RDW_MODE("NEW"), .INIT_VALUE(INIT_B)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b), .init_req(init_req), .busy(busy_b),
    .dbg_state(dbg_state_b), .dbg_sweep_addr(dbg_sweep_b)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- model and scoreboard state ----------------
  logic [DW-1:0] exp_q [2][$];
  int            due_q [2][$];
  logic [DW-1:0] model [2][DEPTH];
  logic [DW-1:0] init_v [2];
  logic [DW-1:0] last_v [2];
  int            cyc = 0;
  int            clear_left = 0;
  logic [AW:0]   sweep = '0;
  logic          pending = 1'b0;
  logic          exp_busy = 1'b0;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Applies one rising edge to the model using the inputs currently driven.
  task automatic model_edge();
    logic [DW-1:0] nw;
    if (!rst_n) return;
    if (clear_left > 0) begin
      for (int i = 0; i < 2; i++) model[i][sweep[AW-1:0]] = init_v[i];
      sweep = sweep + 1'b1;
      clear_left--;
    end else if (init_req || pending) begin
      pending    = 1'b0;
      clear_left = DEPTH;
      sweep      = '0;
    end else begin
      if (rd_en) begin
        exp_q[0].push_back(model[0][rd_addr]);
        due_q[0].push_back(cyc);
        nw = model[1][rd_addr];
        if (wr_en && (wr_addr == rd_addr)) begin
          for (int l = 0; l < NL; l++) if (wr_be[l]) nw[l*8 +: 8] = wr_data[l*8 +: 8];
        end
        exp_q[1].push_back(nw);
        due_q[1].push_back(cyc + 1);
      end
      if (wr_en) begin
        for (int i = 0; i < 2; i++)
          for (int l = 0; l < NL; l++)
            if (wr_be[l]) model[i][wr_addr][l*8 +: 8] = wr_data[l*8 +: 8];
      end
    end
    exp_busy = (clear_left > 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                             input logic [NL-1:0] be, input logic re, input logic [AW-1:0] ra,
                             input logic ini);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en = re; rd_addr = ra; init_req = ini;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    wr_en = 1'b0; rd_en = 1'b0; init_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive_cycle(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic random_cycle();
    logic [AW-1:0] wa;
    wa = AW'($urandom_range(0, DEPTH - 1));
    drive_cycle(1'($urandom_range(0, 1)), wa, $urandom, NL'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1)),
                1'($urandom_range(0, 1)));
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) drive_cycle(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b0);
    idle(3);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_q[i].delete();
      due_q[i].delete();
      last_v[i] = '0;
    end
    pending = 1'b1; clear_left = 0; sweep = '0; exp_busy = 1'b0;
    #1;
    check("a_rst_valid_now", 32'(rd_valid_a), 32'd0);
    check("a_rst_data_now", rd_data_a, 32'd0);
    check("b_rst_valid_now", 32'(rd_valid_b), 32'd0);
    check("b_rst_data_now", rd_data_b, 32'd0);
    idle(2);
    rst_n = 1'b1;
  endtask

  // Counts busy cycles over a 20-cycle window; random traffic is driven only while clearing.
  task automatic busy_window(input string tag, input int pre, input bit noisy);
    int cnt;
    cnt = pre;
    for (int k = 0; k < 20; k++) begin
      if (noisy && exp_busy) random_cycle();
      else idle(1);
      #3;
      if (busy_a) cnt++;
    end
    check(tag, 32'(cnt), 32'(DEPTH));
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic mon(input int i, input logic v, input logic [DW-1:0] d);
    string         p;
    logic [DW-1:0] e;
    int            due;
    p = (i == 0) ? "a_" : "b_";
    if (v) begin
      if (exp_q[i].size() == 0) begin
        check({p, "rd_valid_spurious"}, 32'(v), 32'd0);
      end else begin
        e   = exp_q[i].pop_front();
        due = due_q[i].pop_front();
        check({p, "rd_data"}, d, e);
        check({p, "rd_latency"}, 32'(cyc), 32'(due));
        last_v[i] = e;
      end
    end else begin
      check({p, "rd_data_hold"}, d, last_v[i]);
      if (due_q[i].size() > 0 && due_q[i][0] <= cyc) begin
        check({p, "rd_valid_missing"}, 32'(v), 32'd1);
        void'(exp_q[i].pop_front());
        void'(due_q[i].pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check("a_rst_valid", 32'(rd_valid_a), 32'd0);
      check("a_rst_data", rd_data_a, 32'd0);
      check("b_rst_valid", 32'(rd_valid_b), 32'd0);
      check("b_rst_data", rd_data_b, 32'd0);
      check("a_rst_busy", 32'(busy_a), 32'd0);
    end else begin
      check("a_busy", 32'(busy_a), 32'(exp_busy));
      check("b_busy", 32'(busy_b), 32'(exp_busy));
      check("a_dbg_state", 32'(dbg_state_a), 32'(exp_busy));
      check("a_sweep_addr", 32'(dbg_sweep_a), 32'(sweep[AW-1:0]));
      check("b_sweep_addr", 32'(dbg_sweep_b), 32'(sweep[AW-1:0]));
      mon(0, rd_valid_a, rd_data_a);
      mon(1, rd_valid_b, rd_data_b);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    init_v[0] = '0;
    init_v[1] = INIT_B;
    last_v[0] = '0;
    last_v[1] = '0;
    #1;
    do_reset();

    // sweep after reset, then every address holds INIT_VALUE
    busy_window("busy_after_reset", 0, 1'b0);
    read_all();

    // byte-lane merge
    drive_cycle(1'b1, 4'd3, 32'hAABB_CCDD, 4'b1111, 1'b0, '0, 1'b0);
    drive_cycle(1'b1, 4'd3, 32'h1122_3344, 4'b0101, 1'b0, '0, 1'b0);
    drive_cycle(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b0);
    idle(3);
    check("lane_merge_model", model[0][3], 32'hAA22_CC44);
    // wr_be = 0 leaves the word unchanged
    drive_cycle(1'b1, 4'd3, 32'hFFFF_FFFF, 4'b0000, 1'b0, '0, 1'b0);
    drive_cycle(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b0);
    idle(3);

    // back-to-back reads
    for (int a = 0; a < 4; a++)
      drive_cycle(1'b1, AW'(a), 32'h1020_3040 + 32'h0101_0101 * a, 4'b1111, 1'b0, '0, 1'b0);
    for (int a = 0; a < 4; a++) drive_cycle(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b0);
    idle(3);

    // read-during-write, full and partial lanes
    drive_cycle(1'b1, 4'd5, 32'h0, 4'b1111, 1'b0, '0, 1'b0);
    drive_cycle(1'b1, 4'd5, 32'h1234_5678, 4'b1111, 1'b1, 4'd5, 1'b0);
    idle(2);
    drive_cycle(1'b1, 4'd5, 32'hCAFE_F00D, 4'b0011, 1'b1, 4'd5, 1'b0);
    drive_cycle(1'b0, '0, '0, '0, 1'b1, 4'd5, 1'b0);
    idle(3);

    // random traffic without sweeps
    for (int k = 0; k < 300; k++) begin
      logic [AW-1:0] wa;
      wa = AW'($urandom_range(0, DEPTH - 1));
      drive_cycle(1'($urandom_range(0, 1)), wa, $urandom, NL'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1)), 1'b0);
    end
    idle(3);

    // init_req beats a same-cycle write/read; in-flight read completes; traffic ignored while busy
    drive_cycle(1'b1, 4'd2, 32'h2222_2222, 4'b1111, 1'b0, '0, 1'b0);
    drive_cycle(1'b0, '0, '0, '0, 1'b1, 4'd2, 1'b0);
    drive_cycle(1'b1, 4'd2, 32'hDEAD_BEEF, 4'b1111, 1'b1, 4'd2, 1'b1);
    #3;
    busy_window("busy_after_init_req", busy_a ? 1 : 0, 1'b1);
    drive_cycle(1'b0, '0, '0, '0, 1'b1, 4'd2, 1'b0);
    idle(3);
    read_all();

    // reset in the middle of a sweep
    drive_cycle(1'b1, 4'd9, 32'h9999_9999, 4'b1111, 1'b0, '0, 1'b0);
    drive_cycle(1'b0, '0, '0, '0, 1'b1, 4'd9, 1'b0);
    idle(3);
    drive_cycle(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
    for (int k = 0; k < 20 && sweep != 5'd7; k++) idle(1);
    check("midsweep_reached_7", 32'(sweep), 32'd7);
    do_reset();
    busy_window("busy_after_midsweep_reset", 0, 1'b0);
    read_all();

    idle(4);
    check("a_queue_empty", 32'(exp_q[0].size()), 32'd0);
    check("b_queue_empty", 32'(exp_q[1].size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
